// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 4-bit ALU between N_REQ requesters.
// The granted requester's operands are steered combinationally to the ALU and
// the ALU result is captured into a single-entry output register.
module alu_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [4*N_REQ-1:0]   req_a,
  input  logic [4*N_REQ-1:0]   req_b,
  input  logic [3*N_REQ-1:0]   req_sel,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_sel,
  input  logic [3:0]           alu_out,
  input  logic                 alu_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_data,
  output logic                 rsp_carry,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_illegal
);

  localparam logic [IDW-1:0] LastIdx = IDW'(N_REQ - 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q;
  logic [3:0]     rsp_data_q;
  logic           rsp_carry_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_illegal_q;

  logic           slot_free;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  int unsigned    rr_sum;
  logic [IDW-1:0] rr_idx;

  // Reset gating keeps req_ready low while rst_n is asserted.
  assign slot_free = rst_n & (~rsp_valid_q | rsp_ready);

  // Round-robin search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_sum      = 0;
    rr_idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_sum = int'(ptr_q) + k;
      if (rr_sum >= N_REQ) rr_sum = rr_sum - N_REQ;
      rr_idx = IDW'(rr_sum);
      if (!grant_found && req_valid[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
    if (!slot_free) grant_found = 1'b0;
  end

  // One-hot grant and ALU operand steering; idle opcode makes the ALU output 0.
  always_comb begin
    req_ready = '0;
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_sel   = 3'b111;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_found && (grant_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
        alu_a        = req_a[i*4 +: 4];
        alu_b        = req_b[i*4 +: 4];
        alu_sel      = req_sel[i*3 +: 3];
      end
    end
  end

  // Pointer advances past the granted index; holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_found) begin
      ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + IDW'(1);
    end
  end

  // Output register: capture on grant, drain on accept, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 4'h0;
      rsp_carry_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (grant_found) begin
        rsp_valid_q   <= 1'b1;
        rsp_data_q    <= alu_out;
        rsp_carry_q   <= alu_carry;
        rsp_id_q      <= grant_idx;
        rsp_illegal_q <= (alu_sel >= 3'b101);
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule
